inst_fetch_queue: RTL

//  Parametrised instruction fetch queue between the IF stage and the launch/ID stage.

---
 rtl/inst_fetch_queue_if.sv | 28 ++
 rtl/inst_fetch_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side push bus and issue-side pop bus of the instruction fetch queue.
interface inst_fetch_queue_if #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned EXC_W  = 7
);
   logic [LANES-1:0]        in_valid_i;
   logic [LANES*PC_W-1:0]   in_pc_i;
   logic [LANES*INST_W-1:0] in_inst_i;
   logic [LANES*EXC_W-1:0]  in_exc_i;
   logic                    in_allowin_o;
   logic [LANES-1:0]        out_valid_o;
   logic [LANES*PC_W-1:0]   out_pc_o;
   logic [LANES*INST_W-1:0] out_inst_o;
   logic [LANES*EXC_W-1:0]  out_exc_o;
   logic [LANES-1:0]        out_accept_i;

   modport master (
      output in_valid_i, in_pc_i, in_inst_i, in_exc_i, out_accept_i,
      input  in_allowin_o, out_valid_o, out_pc_o, out_inst_o, out_exc_o
   );

   modport slave (
      input  in_valid_i, in_pc_i, in_inst_i, in_exc_i, out_accept_i,
      output in_allowin_o, out_valid_o, out_pc_o, out_inst_o, out_exc_o
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Multi-lane circular instruction fetch queue between IF and ID/launch.
// Define IFQ_PERF_CNT_EN to add the stall/empty performance counters.
module inst_fetch_queue #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned EXC_W  = 7
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   inst_fetch_queue_if.slave            ifq,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [31:0]                  stall_cnt_o,
   output logic [31:0]                  empty_cnt_o
`endif
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned ENT_W = EXC_W + PC_W + INST_W;

   logic [ENT_W-1:0] ram [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count, push_n, pop_n;
   logic             allowin, push_run, pop_run;

   // Registered count only: a same-cycle pop never opens the input side.
   assign allowin          = (DEPTH - 32'(count)) >= LANES;
   assign ifq.in_allowin_o = allowin;
   assign count_o          = count;

   always_comb begin
      ifq.out_valid_o = '0;
      ifq.out_pc_o    = '0;
      ifq.out_inst_o  = '0;
      ifq.out_exc_o   = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         ifq.out_valid_o[k]                 = CNT_W'(k) < count;
         ifq.out_inst_o[k*INST_W +: INST_W] = ram[head + PTR_W'(k)][0 +: INST_W];
         ifq.out_pc_o[k*PC_W +: PC_W]       = ram[head + PTR_W'(k)][INST_W +: PC_W];
         ifq.out_exc_o[k*EXC_W +: EXC_W]    = ram[head + PTR_W'(k)][INST_W+PC_W +: EXC_W];
      end
   end

   // Only the contiguous prefix from lane0 counts on either side.
   always_comb begin
      push_n   = '0;
      pop_n    = '0;
      push_run = 1'b1;
      pop_run  = 1'b1;
      for (int unsigned k = 0; k < LANES; k++) begin
         push_run = push_run & ifq.in_valid_i[k];
         pop_run  = pop_run & ifq.out_accept_i[k] & ifq.out_valid_o[k];
         if (push_run) push_n = push_n + CNT_W'(1);
         if (pop_run)  pop_n  = pop_n + CNT_W'(1);
      end
      if (!allowin) push_n = '0;
   end

   always_ff @(posedge clk) begin
      if (!flush_i) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            if (CNT_W'(k) < push_n)
               ram[tail + PTR_W'(k)] <= {ifq.in_exc_i[k*EXC_W +: EXC_W],
                                         ifq.in_pc_i[k*PC_W +: PC_W],
                                         ifq.in_inst_i[k*INST_W +: INST_W]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(push_n);
         count <= count + push_n - pop_n;
      end
   end

`ifdef IFQ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= '0;
         empty_cnt_o <= '0;
      end else begin
         if ((|ifq.in_valid_i) && !allowin && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if ((count == '0) && !flush_i && (empty_cnt_o != '1))
            empty_cnt_o <= empty_cnt_o + 32'd1;
      end
   end
`endif
endmodule
